mul_div_sequencer: RTL and testbench

MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

---
 rtl/riscv_pkg.sv | 13 +
 rtl/mul_div_sequencer.sv | 115 +++++++++++
 tb/tb_mul_div_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32M constants and the multiply/divide sequencer state type.
package riscv_pkg;
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} mdu_state_e;
  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
endpackage

// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: iterative radix-2 RV32M multiply/divide unit that stalls EX until done.
module mul_div_sequencer
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output logic             busy,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);
  mdu_state_e         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d, rneg_q, rneg_d;
  logic               s1, s2, is_div, div0, ovf;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     msum, dtmp, dsub;
  logic               dge;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
  logic [WIDTH-1:0]   quo, rem;
  assign busy         = state_q != IDLE;
  assign result_valid = state_q == DONE;
  assign stall        = (start & ~busy) | (busy & ~result_valid);
  assign result       = result_q;
  always_comb begin
    is_div = funct3[2];
    s1     = is_div ? ~funct3[0] : funct3 != MULHU;
    s2     = is_div ? ~funct3[0] : ~funct3[1];
    a_mag  = (s1 && rs1_data[WIDTH-1]) ? -rs1_data : rs1_data;
    b_mag  = (s2 && rs2_data[WIDTH-1]) ? -rs2_data : rs2_data;
    div0   = is_div && rs2_data == '0;
    ovf    = is_div && !funct3[0] && rs1_data == {1'b1, {(WIDTH-1){1'b0}}} && rs2_data == '1;
    // Shift-add multiply keeps the multiplier in the low half; restoring divide keeps the dividend there.
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nx = {msum, acc_q[WIDTH-1:1]};
    dtmp   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    dsub   = dtmp - {1'b0, b_q};
    dge    = dtmp >= {1'b0, b_q};
    div_nx = {dge ? dsub[WIDTH-1:0] : dtmp[WIDTH-1:0], acc_q[WIDTH-2:0], dge};
    prod   = neg_q ? -acc_q : acc_q;
    quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: if (start && !flush) begin
        op_d    = funct3;
        a_d     = a_mag;
        b_d     = b_mag;
        neg_d   = (s1 & rs1_data[WIDTH-1]) ^ (s2 & rs2_data[WIDTH-1]);
        rneg_d  = s1 & rs1_data[WIDTH-1];
        cnt_d   = '0;
        acc_d   = {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
        state_d = (div0 || ovf) ? DONE : CALC;
        if (div0) result_d = funct3[1] ? rs1_data : '1;
        else if (ovf) result_d = funct3[1] ? '0 : rs1_data;
      end
      CALC: begin
        acc_d   = op_q[2] ? div_nx : mul_nx;
        cnt_d   = cnt_q + 6'd1;
        state_d = cnt_q == 6'(WIDTH - 1) ? SIGN : CALC;
      end
      SIGN: begin
        result_d = op_q[2] ? (op_q[1] ? rem : quo) : (op_q == MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb_mul_div_sequencer: directed and random RV32M operations against an arithmetic reference model.
module tb_mul_div_sequencer;
  logic        clk = 0, reset = 1, start = 0, flush = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] rs1 = 0, rs2 = 0;
  logic        busy, stall, result_valid;
  logic [31:0] result;
  int vectors = 0, miss = 0;
  localparam logic [31:0] MIN = 32'h8000_0000;

  mul_div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
    .rs1_data(rs1), .rs2_data(rs2), .busy(busy), .stall(stall),
    .result_valid(result_valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    if (!f[2]) begin
      ea = (f != 3'd3) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (f < 3'd2) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return f == 3'd0 ? p[31:0] : p[63:32];
    end
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      if (a == MIN && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : MIN;
      sa = a;
      sb = b;
      return f[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return f[1] ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && (b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF))) ? 1 : 34;
  endfunction

  // Caller sits at a negedge with the unit idle; returns at the negedge after DONE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    logic stall_ok;
    logic [31:0] exp;
    exp = ref_res(f, a, b);
    funct3 = f; rs1 = a; rs2 = b; start = 1;
    #1 stall_ok = stall;
    @(negedge clk);
    start = 0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    n = 1;
    while (!result_valid && n < 60) begin
      stall_ok &= stall;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(ref_lat(f, a, b)));
    check({tag, " result"}, 64'(result), 64'(exp));
    check({tag, " stall_before_done"}, 64'(stall_ok), 64'd1);
    check({tag, " stall_in_done"}, 64'(stall), 64'd0);
    @(negedge clk);
    check({tag, " single_pulse"}, 64'(result_valid), 64'd0);
    check({tag, " idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int seen;
    logic [2:0] f;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset valid", 64'(result_valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    reset = 0;
    @(negedge clk);
    run_op(3'd0, 32'd7, -32'sd3, "mul 7x-3");
    check("mul 7x-3 value", 64'(result), 64'h0000_0000_FFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'd1, MIN, MIN, "mulh min");
    run_op(3'd4, -32'sd7, 32'd2, "div -7/2");
    run_op(3'd6, -32'sd7, 32'd2, "rem -7/2");
    run_op(3'd5, 32'd100, 32'd7, "divu");
    run_op(3'd7, 32'd100, 32'd7, "remu");
    run_op(3'd5, 32'd5, 32'd0, "divu by 0");
    run_op(3'd6, MIN, 32'hFFFF_FFFF, "rem ovf");
    run_op(3'd4, MIN, 32'hFFFF_FFFF, "div ovf");
    run_op(3'd6, 32'd9, 32'd0, "rem by 0");
    // Flush at cycle 10 of a divide.
    funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1;
    @(negedge clk);
    start = 0;
    seen = 0;
    repeat (9) begin
      seen += int'(result_valid);
      @(negedge clk);
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush idle", 64'(busy), 64'd0);
    repeat (40) begin
      seen += int'(result_valid);
      @(negedge clk);
    end
    check("flush no valid", 64'(seen), 64'd0);
    // Flush together with start must not launch an operation.
    funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; start = 1; flush = 1;
    @(negedge clk);
    start = 0; flush = 0;
    check("flush+start ignored", 64'(busy), 64'd0);
    // A start issued mid-operation is ignored.
    funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; start = 1;
    @(negedge clk);
    start = 0;
    seen = 6;
    while (!result_valid && seen < 60) begin
      @(negedge clk);
      seen++;
    end
    check("busy start latency", 64'(seen), 64'd34);
    check("busy start result", 64'(result), 64'd14);
    @(negedge clk);
    // Reset at cycle 20 of a multiply.
    funct3 = 3'd0; rs1 = 32'd123; rs2 = 32'd456; start = 1;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset valid", 64'(result_valid), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    check("midreset stall", 64'(stall), 64'd0);
    reset = 0;
    @(negedge clk);
    run_op(3'd0, 32'd3, 32'd4, "mul 3x4");
    check("mul 3x4 value", 64'(result), 64'd12);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = MIN; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(f, a, b, $sformatf("rand%0d f%0d", i, f));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
